// File: rtl/router_pkg.sv
// router_pkg: shared types and helpers for the router read-side scheduler
package router_pkg;
  localparam int NUM_PORTS = 3;
  typedef enum logic [1:0] {IDLE, HDR, HDR_WAIT, BODY} rd_state_t;
  typedef struct packed {
    logic [7:0] data;
    logic [1:0] port;
    logic       last;
    logic       perr;
  } entry_t;
  function automatic logic [5:0] hdr_len(input logic [7:0] hdr);
    return hdr[7:2];
  endfunction
endpackage

// File: rtl/router_rd_skid.sv
// router_rd_skid: DEPTH-entry FIFO of tagged bytes; registered head drives dout
// Ports: clock/reset (sync, active-high), push/din write side, pop read side,
// dout = head entry, count = occupied entries.
module router_rd_skid
  import router_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  entry_t                   din,
  input  logic                     pop,
  output entry_t                   dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    mem_d[wr_q] = push ? din : mem_q[wr_q];
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/router_rd_sched.sv
// router_rd_sched: round-robin packet reader for the 3 router FIFOs with parity check and wait timeout
// Ports: clock/reset (sync, active-high); vld_out/data_out/read_enb talk to the port FIFOs;
// m_data/m_port/m_last/m_perr/m_valid/m_ready form the tagged output byte stream;
// wait_err pulses when a port has waited TIMEOUT_CYC cycles unread.
module router_rd_sched
  import router_pkg::*;
#(
  parameter int BUF_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 30
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_PORTS-1:0]       vld_out,
  input  logic [NUM_PORTS-1:0][7:0]  data_out,
  output logic [NUM_PORTS-1:0]       read_enb,
  output logic [7:0]                 m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [1:0]                 m_port,
  output logic                       m_last,
  output logic                       m_perr,
  output logic [NUM_PORTS-1:0]       wait_err
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  rd_state_t state_q, state_d;
  logic [1:0] g_q, g_d, lg_q, lg_d, pick, cand;
  logic any, rd, room;
  logic [6:0] rd_left_q, rd_left_d;
  logic inf_q, inf_d;
  logic [1:0] inf_port_q, inf_port_d;
  logic [6:0] idx_q, idx_d;
  logic [5:0] len_q, len_d;
  logic [7:0] x_q, x_d, byte_in;
  logic is_last;
  entry_t push_e, head;
  logic [CW-1:0] count;
  logic [NUM_PORTS-1:0][TW-1:0] wc_q, wc_d;
  logic [NUM_PORTS-1:0] werr_q, werr_d;
  // Descending scan so the port closest after last_grant is the one left in pick.
  always_comb begin
    pick = lg_q;
    any = 1'b0;
    cand = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = 2'((int'(lg_q) + k) % NUM_PORTS);
      if (vld_out[cand]) begin
        pick = cand;
        any = 1'b1;
      end
    end
  end
  // A read in flight already owns a buffer slot.
  assign room = (count + CW'(inf_q)) < CW'(BUF_DEPTH);
  always_comb begin
    state_d = state_q;
    g_d = g_q;
    lg_d = lg_q;
    rd_left_d = rd_left_q;
    rd = 1'b0;
    unique case (state_q)
      IDLE: begin
        g_d = any ? pick : g_q;
        state_d = any ? HDR : IDLE;
      end
      HDR: begin
        rd = vld_out[g_q] && room;
        state_d = rd ? HDR_WAIT : HDR;
      end
      HDR_WAIT: begin
        rd_left_d = {1'b0, hdr_len(data_out[g_q])} + 7'd1;
        state_d = BODY;
      end
      BODY: begin
        rd = vld_out[g_q] && room;
        rd_left_d = rd ? rd_left_q - 7'd1 : rd_left_q;
        lg_d = (rd && rd_left_q == 7'd1) ? g_q : lg_q;
        state_d = (rd && rd_left_q == 7'd1) ? IDLE : BODY;
      end
      default: state_d = IDLE;
    endcase
  end
  assign read_enb = (rd && !reset) ? (NUM_PORTS'(1) << g_q) : '0;
  assign inf_d = rd;
  assign inf_port_d = g_q;
  // Arrival side tracks packet position independently of the read side so the
  // next packet's header may be read while this one's tail is still landing.
  always_comb begin
    byte_in = data_out[inf_port_q];
    is_last = (idx_q != '0) && (idx_q == {1'b0, len_q} + 7'd1);
    push_e = '{data: byte_in, port: inf_port_q, last: is_last, perr: is_last && (x_q != byte_in)};
    idx_d = idx_q;
    len_d = len_q;
    x_d = x_q;
    if (inf_q) begin
      idx_d = is_last ? '0 : idx_q + 7'd1;
      len_d = (idx_q == '0) ? hdr_len(byte_in) : len_q;
      x_d = (idx_q == '0) ? byte_in : x_q ^ byte_in;
    end
  end
  always_comb begin
    wc_d = wc_q;
    werr_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      wc_d[i] = !(vld_out[i] && !read_enb[i]) ? '0 :
                (wc_q[i] == TW'(TIMEOUT_CYC)) ? wc_q[i] : wc_q[i] + TW'(1);
      werr_d[i] = vld_out[i] && !read_enb[i] && (wc_q[i] == TW'(TIMEOUT_CYC - 1));
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      g_q <= '0;
      lg_q <= 2'd2;
      rd_left_q <= '0;
      inf_q <= 1'b0;
      inf_port_q <= '0;
      idx_q <= '0;
      len_q <= '0;
      x_q <= '0;
      wc_q <= '0;
      werr_q <= '0;
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      lg_q <= lg_d;
      rd_left_q <= rd_left_d;
      inf_q <= inf_d;
      inf_port_q <= inf_port_d;
      idx_q <= idx_d;
      len_q <= len_d;
      x_q <= x_d;
      wc_q <= wc_d;
      werr_q <= werr_d;
    end
  end
  router_rd_skid #(.DEPTH(BUF_DEPTH)) u_skid (
    .clock (clock),
    .reset (reset),
    .push  (inf_q),
    .din   (push_e),
    .pop   (m_valid && m_ready),
    .dout  (head),
    .count (count)
  );
  assign m_valid = count != '0;
  assign m_data = head.data;
  assign m_port = head.port;
  assign m_last = head.last;
  assign m_perr = head.perr;
  assign wait_err = werr_q;
endmodule

// File: tb/tb_router_rd_sched.sv
// tb_router_rd_sched: scoreboard bench with modelled port FIFOs and directed packets
module tb_router_rd_sched;
  logic clock = 1'b0, reset = 1'b1, m_ready = 1'b1;
  logic [2:0] vld_out = '0;
  logic [2:0][7:0] data_out = '0;
  logic [2:0] read_enb, wait_err;
  logic [7:0] m_data;
  logic m_valid, m_last, m_perr;
  logic [1:0] m_port;
  router_rd_sched #(.BUF_DEPTH(4), .TIMEOUT_CYC(30)) dut (
    .clock(clock), .reset(reset), .vld_out(vld_out), .data_out(data_out),
    .read_enb(read_enb), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_port(m_port), .m_last(m_last), .m_perr(m_perr), .wait_err(wait_err)
  );
  always #5 clock = ~clock;
  int total = 0, bad = 0, cyc = 0;
  logic [7:0] pq[3][$];
  logic [11:0] exp_q[$];
  logic [7:0] pkt[$];
  logic [2:0] re_s = '0;
  logic hs_s = 1'b0, bp_en = 1'b0, v2_prev = 1'b0, pv = 1'b0, pr = 1'b0;
  logic [11:0] prev_o = '0;
  int outst = 0, max_out = 0, mh = 0, stable_bad = 0, bp_n = 0, v2_rise = 0;
  int werr_n[3], werr_cyc[3];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, req, cyc);
    end
  endtask
  // Port FIFO model: a read sampled at an edge presents its byte just after it.
  always @(posedge clock) begin
    cyc++;
    outst = reset ? 0 : outst + $countones(re_s) - int'(hs_s);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (re_s[i]) begin
        chk("empty_read", 32'(pq[i].size() == 0), 0);
        if (pq[i].size() != 0) data_out[i] = pq[i].pop_front();
      end
      vld_out[i] = pq[i].size() != 0;
    end
  end
  always @(posedge clock) begin
    #1;
    if (bp_en) begin
      bp_n++;
      if (bp_n == 3) begin
        bp_n = 0;
        m_ready = ~m_ready;
      end
    end else begin
      bp_n = 0;
      m_ready = 1'b1;
    end
  end
  always @(negedge clock) begin
    re_s = read_enb;
    hs_s = !reset && m_valid && m_ready;
    if ($countones(read_enb) > 1) mh++;
    if (outst > max_out) max_out = outst;
    if (!reset) begin
      for (int i = 0; i < 3; i++)
        if (wait_err[i]) begin
          werr_n[i]++;
          werr_cyc[i] = cyc;
        end
      if (vld_out[2] && !v2_prev) v2_rise = cyc;
      if (pv && !pr && m_valid && {m_data, m_port, m_last, m_perr} != prev_o) stable_bad++;
      if (hs_s) begin
        if (exp_q.size() == 0) chk("unexpected_byte", 1, 0);
        else chk("byte", {m_data, m_port, m_last, m_perr}, exp_q.pop_front());
      end
    end
    v2_prev = vld_out[2];
    pv = m_valid && !reset;
    pr = m_ready;
    prev_o = {m_data, m_port, m_last, m_perr};
  end
  task automatic load(input int p, input logic perr);
    for (int k = 0; k < pkt.size(); k++) begin
      pq[p].push_back(pkt[k]);
      exp_q.push_back({pkt[k], 2'(p), k == pkt.size() - 1, (k == pkt.size() - 1) && perr});
    end
  endtask
  task automatic mk(input int len, input logic [1:0] addr, input logic [7:0] seed);
    logic [7:0] x, b;
    pkt.delete();
    pkt.push_back({6'(len), addr});
    x = pkt[0];
    for (int k = 0; k < len; k++) begin
      b = seed + 8'(k);
      pkt.push_back(b);
      x ^= b;
    end
    pkt.push_back(x);
  endtask
  task automatic drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(posedge clock);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (4) @(posedge clock);
  endtask
  task automatic rst();
    @(posedge clock);
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) pq[i].delete();
    exp_q.delete();
    @(posedge clock);
    #2 reset = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 3; i++) begin
      werr_n[i] = 0;
      werr_cyc[i] = 0;
    end
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    chk("rst_read_enb", read_enb, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_wait_err", wait_err, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_port", m_port, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_perr", m_perr, 0);
    @(posedge clock);
    #2;
    pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    load(1, 1'b0);
    drain(60);
    rst();
    mk(2, 2'd0, 8'h10); load(0, 1'b0);
    mk(2, 2'd1, 8'h20); load(1, 1'b0);
    mk(2, 2'd2, 8'h30); load(2, 1'b0);
    mk(2, 2'd0, 8'h50); load(0, 1'b0);
    drain(120);
    rst();
    pkt = '{8'h04, 8'hAA, 8'h00};
    load(2, 1'b1);
    drain(60);
    rst();
    max_out = 0;
    bp_en = 1'b1;
    mk(10, 2'd1, 8'h80); load(1, 1'b0);
    drain(300);
    bp_en = 1'b0;
    chk("buf_over_4", 32'(max_out > 4), 0);
    rst();
    for (int i = 0; i < 3; i++) werr_n[i] = 0;
    mk(63, 2'd0, 8'h40); load(0, 1'b0);
    pkt = '{8'h02, 8'h02};
    load(2, 1'b0);
    drain(400);
    chk("werr2_pulses", werr_n[2], 1);
    chk("werr2_delay", werr_cyc[2] - v2_rise, 30);
    chk("werr0_pulses", werr_n[0], 0);
    rst();
    mk(10, 2'd0, 8'h60); load(0, 1'b0);
    repeat (6) @(posedge clock);
    #2 reset = 1'b1;
    exp_q.delete();
    @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    chk("midrst_read_enb", read_enb, 0);
    chk("midrst_m_valid", m_valid, 0);
    rst();
    pkt = '{8'h00, 8'h00};
    load(0, 1'b0);
    drain(60);
    chk("multi_hot", mh, 0);
    chk("held_stable", stable_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
